// File: rtl/pc_sequencer.sv
// pc_sequencer: sequenced PC update with instruction fetch handshake and redirect/exception selection
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h80)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcNext,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  input  logic             irq,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       cause
);
  typedef enum logic [1:0] {BOOT, FETCH, ISSUE} state_t;
  state_t state, state_next;
  logic irq_pending;
  logic accept;
  logic redirect;
  logic misaligned;
  logic [1:0] exc_cause;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target;
  assign accept = (state == ISSUE) && !stall;
  assign pc_inc = pc + WIDTH'(4);
  assign target = jump ? jump_target : branch_target;
  assign redirect = jump | branch_taken;
  assign misaligned = redirect && (target[1:0] != 2'b00);
  assign exc_cause = exc ? 2'd3 : irq_pending ? 2'd1 : misaligned ? 2'd2 : 2'd0;
  assign imem_req = (state == FETCH);
  assign imem_addr = pc;
  // Next-PC selection; only meaningful while an instruction is being issued
  always_comb begin
    pcNext = pc;
    if (state == ISSUE)
      pcNext = (exc_cause != 2'd0) ? EXC_VECTOR : redirect ? target : pc_inc;
  end
  // Next-state: boot once, wait for memory ack, then wait for decode to accept
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = FETCH;
      FETCH:   state_next = imem_ack ? ISSUE : FETCH;
      ISSUE:   state_next = stall ? ISSUE : FETCH;
      default: state_next = BOOT;
    endcase
  end
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else state <= state_next;
  end
  // Datapath: capture fetched word, advance pc on accept, record exception entry
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
      instr <= '0;
      instr_valid <= 1'b0;
      epc <= '0;
      cause <= 2'd0;
      irq_pending <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (accept) begin
        instr_valid <= 1'b0;
        pc <= pcNext;
        if (exc_cause != 2'd0) begin
          cause <= exc_cause;
          epc <= (exc_cause == 2'd2) ? target : pc_inc;
        end
      end
      irq_pending <= irq | (irq_pending & ~(accept && exc_cause == 2'd1));
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc, pc_next, imem_addr, instr, epc;
  logic        imem_req, instr_valid;
  logic [1:0]  cause;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        exc = 1'b0;
  logic        irq = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] epc;
    logic [1:0]  cause;
    int          gap;
  } fexp_t;
  typedef struct {
    logic [31:0] instr;
    int          cycles;
  } iexp_t;
  fexp_t fq[$];
  iexp_t iq[$];
  logic [31:0] cur;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc(pc), .pcNext(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc(exc), .irq(irq),
    .epc(epc), .cause(cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int cyc = 0;
  int last_fetch = 0;
  int vcnt = 0;
  logic req_q = 1'b0;
  logic valid_q = 1'b0;
  fexp_t fe;
  iexp_t ie;

  always @(negedge clk) begin
    cyc++;
    if (imem_req && !req_q) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_unexpected: got addr %h expected none", imem_addr);
      end else begin
        fe = fq.pop_front();
        chk("fetch_addr", imem_addr, fe.addr);
        chk("pc", pc, fe.addr);
        chk("epc", epc, fe.epc);
        chk("cause", {30'b0, cause}, {30'b0, fe.cause});
        if (fe.gap >= 0) chk("fetch_gap", 32'(cyc - last_fetch), 32'(fe.gap));
      end
      last_fetch = cyc;
    end
    if (instr_valid && !valid_q) begin
      if (iq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got instr %h expected none", instr);
      end else begin
        ie = iq.pop_front();
        chk("instr", instr, ie.instr);
      end
      vcnt = 1;
    end else if (instr_valid) begin
      vcnt++;
      chk("instr_hold", instr, ie.instr);
    end
    if (instr_valid) chk("req_in_issue", {31'b0, imem_req}, 32'd0);
    if (!instr_valid && valid_q) chk("valid_cycles", 32'(vcnt), 32'(ie.cycles));
    req_q = imem_req;
    valid_q = instr_valid;
  end

  task automatic step(input int dly, input int stl, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic ex, input logic ir,
                      input logic [31:0] nx, input logic [31:0] ep, input logic [1:0] cs, input int gap);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no request expected request at %h", cur);
    end
    irq = ir;
    repeat (dly) begin
      @(posedge clk); #1;
      irq = 1'b0;
    end
    imem_ack = 1'b1;
    imem_rdata = rd(imem_addr);
    iq.push_back('{instr: rd(cur), cycles: stl + 1});
    @(posedge clk); #1;
    imem_ack = 1'b0;
    irq = 1'b0;
    stall = 1'b1;
    repeat (stl) begin
      @(posedge clk); #1;
    end
    stall = 1'b0;
    branch_taken = br;
    branch_target = bt;
    jump = jp;
    jump_target = jt;
    exc = ex;
    fq.push_back('{addr: nx, epc: ep, cause: cs, gap: gap});
    @(posedge clk); #1;
    branch_taken = 1'b0;
    jump = 1'b0;
    exc = 1'b0;
    cur = nx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", {30'b0, cause}, 32'd0);
    chk("boot_pcnext", pc_next, 32'h0);
    fq.push_back('{addr: 32'h0, epc: 32'h0, cause: 2'd0, gap: -1});
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 2'd0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h0, 2'd0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 32'h0, 2'd0, 2);
    step(3, 2, 0, 0, 0, 0, 0, 0, 32'h10, 32'h0, 2'd0, 7);
    step(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 32'h0, 2'd0, -1);
    step(0, 0, 1, 32'h200, 1, 32'h100, 0, 0, 32'h100, 32'h0, 2'd0, -1);
    step(0, 0, 0, 0, 1, 32'h20, 0, 0, 32'h20, 32'h0, 2'd0, -1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h80, 32'h24, 2'd1, -1);
    step(0, 0, 0, 0, 1, 32'h20, 0, 0, 32'h20, 32'h24, 2'd1, -1);
    step(1, 0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h24, 2'd3, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 32'h84, 2'd1, -1);
    step(0, 0, 0, 0, 1, 32'h102, 0, 0, 32'h80, 32'h102, 2'd2, -1);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h102, 2'd2, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h102, 2'd2, -1);
    step(0, 0, 1, 32'h31, 0, 0, 0, 0, 32'h80, 32'h31, 2'd2, -1);
    step(0, 0, 0, 0, 1, 32'h30, 0, 0, 32'h30, 32'h31, 2'd2, -1);
    @(posedge clk); #1;
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    fq.push_back('{addr: 32'h0, epc: 32'h0, cause: 2'd0, gap: -1});
    @(posedge clk); #1;
    reset = 1'b0;
    imem_ack = 1'b0;
    chk("midfetch_rst_pc", pc, 32'h0);
    chk("midfetch_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midfetch_rst_req", {31'b0, imem_req}, 32'd0);
    chk("midfetch_rst_instr", instr, 32'h0);
    cur = 32'h0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 2'd0, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("fetch_queue_empty", 32'(fq.size()), 32'd0);
    chk("issue_queue_empty", 32'(iq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
